// File: rtl/stereo_matrix_scaler_if.sv
// Stream interface of the stereo matrix scaler: one sample-pair input channel
// and one scaled result channel.
interface stereo_matrix_scaler_if #(
  parameter int DW = 18,
  parameter int KW = 4
);
  // Handshake: a beat moves on a rising edge where valid and ready are both 1.
  // The producer holds valid and data stable until that edge; ready may change freely.
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] left;
  logic signed [DW-1:0] right;
  logic [KW-1:0]        ks;
  logic [KW-1:0]        kd;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_sum;
  logic signed [DW-1:0] out_dif;
  logic                 sat_sum;
  logic                 sat_dif;

  modport master (
    output in_valid, left, right, ks, kd, out_ready,
    input  in_ready, out_valid, out_sum, out_dif, sat_sum, sat_dif
  );

  modport slave (
    input  in_valid, left, right, ks, kd, out_ready,
    output in_ready, out_valid, out_sum, out_dif, sat_sum, sat_dif
  );
endinterface

// File: rtl/stereo_matrix_scaler.sv
// Mid/side matrix with gain: (L+R)*Ks and (L-R)*Kd through one shared serial
// shift-add multiplier, then rounding, fractional shift and saturation.
module stereo_matrix_scaler #(
  parameter int DW    = 18,
  parameter int KW    = 4,
  parameter int FRAC  = 3,
  parameter int ROUND = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  stereo_matrix_scaler_if.slave bus,
  output logic [1:0]            state_o
);

  localparam int PW = DW + KW;
  localparam int CW = (KW > 1) ? $clog2(KW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(KW - 1);
  localparam logic [DW-1:0] MAX_DW = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_DW = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [PW:0] MAXV = $signed({{(KW+2){1'b0}}, {(DW-1){1'b1}}});
  localparam logic signed [PW:0] MINV = $signed({{(KW+2){1'b1}}, {(DW-1){1'b0}}});
  localparam logic signed [PW:0] RND =
    (ROUND == 1 && FRAC > 0) ? ((PW+1)'(1) <<< ((FRAC > 0) ? FRAC - 1 : 0)) : '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_SUM = 2'd1,
    MUL_DIF = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Result packing for both helpers: {saturated, value}.
  function automatic logic [DW:0] clamp_in(input logic [DW:0] v);
    if (v[DW] != v[DW-1]) return {1'b1, (v[DW] ? MIN_DW : MAX_DW)};
    return {1'b0, v[DW-1:0]};
  endfunction

  function automatic logic [DW:0] post_scale(input logic signed [PW-1:0] p);
    logic signed [PW:0] r;
    r = ($signed({p[PW-1], p}) + RND) >>> FRAC;
    if (r > MAXV) return {1'b1, MAX_DW};
    if (r < MINV) return {1'b1, MIN_DW};
    return {1'b0, r[DW-1:0]};
  endfunction

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic signed [PW-1:0] acc_q;
  logic signed [DW-1:0] op_sum_q, op_dif_q;
  logic [KW-1:0]        ks_q, kd_q;
  logic                 sat_sum_in_q, sat_dif_in_q;
  logic signed [DW-1:0] res_sum_q;
  logic                 res_sat_sum_q;
  logic signed [DW-1:0] out_sum_q, out_dif_q;
  logic                 sat_sum_q, sat_dif_q;
  logic                 in_ready_q, out_valid_q;

  logic [DW:0]          sum_w, dif_w, sum_c, dif_c, scaled;
  logic signed [DW-1:0] op_cur;
  logic [KW-1:0]        gain_cur;
  logic signed [PW-1:0] op_ext, acc_d;

  always_comb begin
    sum_w    = {bus.left[DW-1], bus.left} + {bus.right[DW-1], bus.right};
    dif_w    = {bus.left[DW-1], bus.left} - {bus.right[DW-1], bus.right};
    sum_c    = clamp_in(sum_w);
    dif_c    = clamp_in(dif_w);
    op_cur   = (state_q == MUL_DIF) ? op_dif_q : op_sum_q;
    gain_cur = (state_q == MUL_DIF) ? kd_q : ks_q;
    op_ext   = {{KW{op_cur[DW-1]}}, op_cur};
    // One gain bit per edge, LSB first: add the operand weighted by 2^bit.
    acc_d    = gain_cur[cnt_q] ? (acc_q + (op_ext <<< cnt_q)) : acc_q;
    scaled   = post_scale(acc_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      op_sum_q      <= '0;
      op_dif_q      <= '0;
      ks_q          <= '0;
      kd_q          <= '0;
      sat_sum_in_q  <= 1'b0;
      sat_dif_in_q  <= 1'b0;
      res_sum_q     <= '0;
      res_sat_sum_q <= 1'b0;
      out_sum_q     <= '0;
      out_dif_q     <= '0;
      sat_sum_q     <= 1'b0;
      sat_dif_q     <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_sum_q     <= sum_c[DW-1:0];
            op_dif_q     <= dif_c[DW-1:0];
            sat_sum_in_q <= sum_c[DW];
            sat_dif_in_q <= dif_c[DW];
            ks_q         <= bus.ks;
            kd_q         <= bus.kd;
            acc_q        <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            state_q      <= MUL_SUM;
          end
        end
        MUL_SUM: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            res_sum_q     <= scaled[DW-1:0];
            res_sat_sum_q <= scaled[DW] | sat_sum_in_q;
            acc_q         <= '0;
            cnt_q         <= '0;
            state_q       <= MUL_DIF;
          end
        end
        MUL_DIF: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            // Visible outputs change only here, so they stay put while DONE stalls.
            out_sum_q   <= res_sum_q;
            sat_sum_q   <= res_sat_sum_q;
            out_dif_q   <= scaled[DW-1:0];
            sat_dif_q   <= scaled[DW] | sat_dif_in_q;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_dif   = out_dif_q;
  assign bus.sat_sum   = sat_sum_q;
  assign bus.sat_dif   = sat_dif_q;
  assign state_o       = state_q;

endmodule
